// File: rtl/m0_mem_arbiter_if.sv
// m0_mem_arbiter_if: fetch, data and memory bus signals shared by the arbiter and its environment
interface m0_mem_arbiter_if #(parameter int AW = 32);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [31:0]   if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic [3:0]    d_be;
  logic          d_gnt;
  logic          d_rvalid;
  logic [31:0]   d_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;
  logic          mem_ack;
  logic          mem_rvalid;
  logic [31:0]   mem_rdata;
  logic          bus_fault;
  modport master (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ack, mem_rvalid, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be, bus_fault
  );
  modport slave (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ack, mem_rvalid, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be, bus_fault
  );
endinterface

// File: rtl/m0_mem_arbiter.sv
// m0_mem_arbiter: shares one single-port memory between the core fetch and data ports
module m0_mem_arbiter #(
  parameter int AW           = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input logic clk,
  input logic rst,
  m0_mem_arbiter_if.master bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t        state;
  logic          own_d;
  logic [SW-1:0] streak;
  logic [TW-1:0] timer;
  logic          sel_d;
  logic [AW-1:0] sel_addr;
  always_comb begin
    sel_d    = bus.d_req && !(bus.if_req && streak == SW'(STARVE_LIMIT));
    sel_addr = sel_d ? bus.d_addr : bus.if_addr;
  end
  // grant is combinational so it coincides with the memory accepting the request
  assign bus.d_gnt  = state == ISSUE && bus.mem_ack && own_d;
  assign bus.if_gnt = state == ISSUE && bus.mem_ack && !own_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      own_d         <= 1'b0;
      streak        <= '0;
      timer         <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_be    <= '0;
      bus.if_rvalid <= 1'b0;
      bus.if_rdata  <= '0;
      bus.d_rvalid  <= 1'b0;
      bus.d_rdata   <= '0;
      bus.bus_fault <= 1'b0;
    end else begin
      bus.if_rvalid <= 1'b0;
      bus.d_rvalid  <= 1'b0;
      case (state)
        IDLE: if (bus.if_req || bus.d_req) begin
          own_d         <= sel_d;
          bus.mem_req   <= 1'b1;
          bus.mem_addr  <= sel_addr;
          bus.mem_we    <= sel_d && bus.d_we;
          bus.mem_wdata <= sel_d ? bus.d_wdata : '0;
          bus.mem_be    <= sel_d ? bus.d_be : 4'hf;
          // streak only grows while a fetch is actually being held off
          streak        <= (sel_d && bus.if_req) ? streak + SW'(streak != SW'(STARVE_LIMIT)) : '0;
          state         <= ISSUE;
        end
        ISSUE: if (bus.mem_ack) begin
          bus.mem_req <= 1'b0;
          timer       <= '0;
          state       <= RESP;
        end
        RESP: if (bus.mem_rvalid || timer == TW'(TIMEOUT - 1)) begin
          if (own_d) begin
            bus.d_rvalid <= 1'b1;
            bus.d_rdata  <= (bus.mem_rvalid && !bus.mem_we) ? bus.mem_rdata : '0;
          end else begin
            bus.if_rvalid <= 1'b1;
            bus.if_rdata  <= bus.mem_rvalid ? bus.mem_rdata : '0;
          end
          if (!bus.mem_rvalid) bus.bus_fault <= 1'b1;
          state <= IDLE;
        end else begin
          timer <= timer + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_m0_mem_arbiter.sv
// tb_m0_mem_arbiter: directed scoreboard bench with a simple memory responder
module tb_m0_mem_arbiter;
  typedef struct {bit is_d; logic [31:0] data;} sb_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int compared = 0;
  int mismatched = 0;
  sb_t sb[$];
  bit gnt_log[$];
  int stall_left = 0;
  bit rv_en = 1'b1;
  bit resp_pending = 1'b0;
  logic [31:0] rd_addr = '0;
  sb_t e;

  m0_mem_arbiter_if #(.AW(32)) b();
  m0_mem_arbiter #(.AW(32), .STARVE_LIMIT(4), .TIMEOUT(8)) dut (.clk(clk), .rst(rst), .bus(b));

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a == 32'h2000_0004) ? 32'hCAFE_F00D : (a ^ 32'hA5A5_0000);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_mem_req"}, b.mem_req, 0);
    chk({tag, "_mem_addr"}, b.mem_addr, 0);
    chk({tag, "_mem_payload"}, {b.mem_we, b.mem_be, b.mem_wdata[26:0]}, 0);
    chk({tag, "_gnt"}, {b.if_gnt, b.d_gnt}, 0);
    chk({tag, "_rvalid"}, {b.if_rvalid, b.d_rvalid}, 0);
    chk({tag, "_if_rdata"}, b.if_rdata, 0);
    chk({tag, "_d_rdata"}, b.d_rdata, 0);
    chk({tag, "_bus_fault"}, b.bus_fault, 0);
  endtask

  // memory: acks after stall_left cycles, answers one cycle after the ack
  initial begin
    b.mem_ack = 1'b0;
    b.mem_rvalid = 1'b0;
    b.mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      b.mem_ack = 1'b0;
      b.mem_rvalid = 1'b0;
      if (rst) resp_pending = 1'b0;
      else if (b.mem_req) begin
        if (stall_left > 0) stall_left--;
        else begin
          b.mem_ack = 1'b1;
          rd_addr = b.mem_addr;
          resp_pending = rv_en;
        end
      end else if (resp_pending) begin
        b.mem_rvalid = 1'b1;
        b.mem_rdata = mem_f(rd_addr);
        resp_pending = 1'b0;
      end
    end
  end

  always @(negedge clk) if (!rst) begin
    if (b.d_rvalid || b.if_rvalid) begin
      chk("rvalid_exclusive", {31'b0, b.d_rvalid & b.if_rvalid}, 0);
      if (sb.size() == 0) chk("unexpected_rvalid", sb.size(), 1);
      else begin
        e = sb.pop_front();
        chk("rsp_owner", {31'b0, b.d_rvalid}, {31'b0, e.is_d});
        chk("rsp_rdata", b.d_rvalid ? b.d_rdata : b.if_rdata, e.data);
      end
    end
    if (b.d_gnt || b.if_gnt) begin
      chk("gnt_exclusive", {31'b0, b.d_gnt & b.if_gnt}, 0);
      gnt_log.push_back(b.d_gnt);
    end
  end

  task automatic d_txn(input bit we, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be, input bit to);
    int n = 0;
    b.d_req = 1'b1; b.d_we = we; b.d_addr = addr; b.d_wdata = wd; b.d_be = be;
    sb.push_back('{1'b1, (we || to) ? 32'h0 : mem_f(addr)});
    do begin @(negedge clk); n++; end while (!b.d_gnt && n < 50);
    chk("d_gnt_seen", {31'b0, b.d_gnt}, 1);
    chk("d_mem_addr", b.mem_addr, addr);
    chk("d_mem_we", {31'b0, b.mem_we}, {31'b0, we});
    chk("d_mem_be", {28'b0, b.mem_be}, {28'b0, be});
    if (we) chk("d_mem_wdata", b.mem_wdata, wd);
    @(posedge clk); #1;
    b.d_req = 1'b0;
  endtask

  task automatic if_txn(input logic [31:0] addr);
    int n = 0;
    b.if_req = 1'b1; b.if_addr = addr;
    sb.push_back('{1'b0, mem_f(addr)});
    do begin @(negedge clk); n++; end while (!b.if_gnt && n < 50);
    chk("if_gnt_seen", {31'b0, b.if_gnt}, 1);
    chk("if_mem_addr", b.mem_addr, addr);
    chk("if_mem_we", {31'b0, b.mem_we}, 0);
    @(posedge clk); #1;
    b.if_req = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
    chk("sb_drain", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int n, k, g0;
    b.if_req = 0; b.if_addr = 0; b.d_req = 0; b.d_we = 0; b.d_addr = 0; b.d_wdata = 0; b.d_be = 0;
    repeat (2) @(negedge clk);
    chk_zero("por");
    @(posedge clk); #1 rst = 1'b0;
    // single read, then data-hold after rvalid
    d_txn(1'b0, 32'h2000_0004, 32'h0, 4'hf, 1'b0);
    drain();
    chk("d_rdata_hold", b.d_rdata, 32'hCAFE_F00D);
    // write returns zero data
    d_txn(1'b1, 32'h2000_0010, 32'h1234_5678, 4'b0011, 1'b0);
    drain();
    if_txn(32'h0000_0200);
    drain();
    // reset in the middle of a response
    rv_en = 1'b0;
    d_txn(1'b0, 32'h2000_0020, 32'h0, 4'hf, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_zero("mid_rst");
    sb.delete();
    rv_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    b.if_req = 1'b1; b.if_addr = 32'h100;
    sb.push_back('{1'b0, mem_f(32'h100)});
    @(negedge clk);
    chk("rst_mem_req_lat0", {31'b0, b.mem_req}, 0);
    @(negedge clk);
    chk("rst_mem_req_lat1", {31'b0, b.mem_req}, 1);
    chk("rst_mem_addr", b.mem_addr, 32'h100);
    chk("rst_if_gnt", {31'b0, b.if_gnt}, 1);
    @(posedge clk); #1 b.if_req = 1'b0;
    drain();
    // contention: D,D,D,D,I repeating
    b.if_req = 1'b1; b.if_addr = 32'h300;
    b.d_req = 1'b1; b.d_we = 1'b0; b.d_addr = 32'h2000_0040; b.d_be = 4'hf;
    for (int i = 0; i < 10; i++) sb.push_back('{(i % 5) != 4, mem_f((i % 5) != 4 ? 32'h2000_0040 : 32'h300)});
    g0 = gnt_log.size();
    k = 0; n = 0;
    while (k < 10 && n < 300) begin
      @(negedge clk); n++;
      if (b.d_gnt || b.if_gnt) k++;
    end
    @(posedge clk); #1;
    b.if_req = 1'b0; b.d_req = 1'b0;
    drain();
    chk("contention_gnts", gnt_log.size() - g0, 10);
    for (int i = 0; i < 10 && g0 + i < gnt_log.size(); i++)
      chk($sformatf("grant_order_%0d", i), {31'b0, gnt_log[g0 + i]}, {31'b0, ((i % 5) != 4)});
    // stalled ack: request held stable, single grant
    g0 = gnt_log.size();
    stall_left = 5;
    b.d_req = 1'b1; b.d_we = 1'b1; b.d_addr = 32'h2000_0080; b.d_wdata = 32'h0BAD_BEEF; b.d_be = 4'b1100;
    sb.push_back('{1'b1, 32'h0});
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_mem_req", {31'b0, b.mem_req}, 1);
      chk("stall_mem_addr", b.mem_addr, 32'h2000_0080);
      chk("stall_mem_wdata", b.mem_wdata, 32'h0BAD_BEEF);
      chk("stall_no_gnt", {31'b0, b.d_gnt}, 0);
    end
    @(negedge clk);
    chk("stall_gnt", {31'b0, b.d_gnt}, 1);
    @(posedge clk); #1 b.d_req = 1'b0;
    drain();
    chk("stall_gnt_count", gnt_log.size() - g0, 1);
    // response timeout
    rv_en = 1'b0;
    d_txn(1'b0, 32'h2000_00C0, 32'h0, 4'hf, 1'b1);
    n = 0;
    do begin @(negedge clk); n++; end while (!b.d_rvalid && n < 40);
    chk("timeout_latency", n, 9);
    chk("timeout_fault", {31'b0, b.bus_fault}, 1);
    rv_en = 1'b1;
    drain();
    if_txn(32'h0000_0400);
    drain();
    chk("fault_sticky", {31'b0, b.bus_fault}, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
